// File: rtl/display_share_arbiter.sv
// display_share_arbiter: round-robin time-sharing of one TM1638 display with minimum dwell and a blank gap.
// Optional macro DISPLAY_ARB_PREEMPT_EN makes requester 0 preempt other owners.
module display_share_arbiter #(
   parameter int clk_mhz = 25,
   parameter int n_req = 3,
   parameter int w_digit = 8,
   parameter int w_led = 8,
   parameter int dwell_ms = 250,
   parameter int dwell_cycles = clk_mhz * 1000 * dwell_ms,
   parameter int w_idx = $clog2(n_req)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [n_req-1:0]         req,
   input  logic [n_req*8-1:0]       seg_in,
   input  logic [n_req*w_digit-1:0] digit_in,
   input  logic [n_req*w_led-1:0]   led_in,
   output logic [7:0]               abcdefgh,
   output logic [w_digit-1:0]       digit,
   output logic [w_led-1:0]         led,
   output logic [n_req-1:0]         gnt,
   output logic [w_idx-1:0]         owner_idx,
   output logic                     switch_pulse
);
   localparam int w_cnt = $clog2(dwell_cycles + 1);
   localparam logic [w_cnt-1:0] cnt_max = w_cnt'(dwell_cycles - 1);
   localparam logic [1:0] IDLE = 2'd0, OWNED = 2'd1, BLANK = 2'd2;
   logic [1:0] state_q, state_d;
   logic [w_cnt-1:0] cnt_q, cnt_d;
   logic [w_idx-1:0] owner_q, owner_d, win, target;
   logic [n_req-1:0] gnt_q, gnt_d;
   logic [7:0] seg_q, seg_d;
   logic [w_digit-1:0] digit_q, digit_d;
   logic [w_led-1:0] led_q, led_d;
   logic pulse_q, pre_q, pre_d, sat, leave, grant, preempt, show;
`ifdef DISPLAY_ARB_PREEMPT_EN
   assign preempt = req[0] && owner_q != '0;
`else
   assign preempt = 1'b0;
`endif
   // Descending scan so the nearest requester after the owner overwrites the rest.
   always_comb begin
      win = owner_q;
      for (int k = n_req; k >= 1; k--)
         if (req[w_idx'((int'(owner_q) + k) % n_req)]) win = w_idx'((int'(owner_q) + k) % n_req);
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      owner_d = owner_q;
      gnt_d = gnt_q;
      pre_d = pre_q;
      sat = cnt_q == cnt_max;
      leave = !req[owner_q] || preempt || (sat && |(req & ~gnt_q));
      grant = state_q != OWNED && (pre_q || |req);
      target = pre_q ? '0 : win;
      if (state_q == OWNED) begin
         state_d = leave ? BLANK : OWNED;
         cnt_d = sat ? cnt_q : cnt_q + 1'b1;
         gnt_d = leave ? '0 : gnt_q;
         pre_d = preempt;
      end else if (grant) begin
         state_d = OWNED;
         cnt_d = '0;
         owner_d = target;
         gnt_d = n_req'(1) << target;
         pre_d = 1'b0;
      end else begin
         state_d = IDLE;
         gnt_d = '0;
      end
      show = state_q == OWNED && !leave;
      seg_d = show ? seg_in[int'(owner_q)*8 +: 8] : '0;
      digit_d = show ? digit_in[int'(owner_q)*w_digit +: w_digit] : '0;
      led_d = show ? led_in[int'(owner_q)*w_led +: w_led] : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         owner_q <= w_idx'(n_req - 1);
         gnt_q <= '0;
         seg_q <= '0;
         digit_q <= '0;
         led_q <= '0;
         pulse_q <= 1'b0;
         pre_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         owner_q <= owner_d;
         gnt_q <= gnt_d;
         seg_q <= seg_d;
         digit_q <= digit_d;
         led_q <= led_d;
         pulse_q <= grant;
         pre_q <= pre_d;
      end
   end
   assign abcdefgh = seg_q;
   assign digit = digit_q;
   assign led = led_q;
   assign gnt = gnt_q;
   assign owner_idx = owner_q;
   assign switch_pulse = pulse_q;
endmodule

// File: tb/tb_display_share_arbiter.sv
// tb_display_share_arbiter: directed checks of grant order, dwell, blank gap, reset and sole-owner hold.
module tb_display_share_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] req = '0;
   logic [23:0] seg_in = {8'h0F, 8'h3C, 8'hA5};
   logic [23:0] digit_in = {8'h04, 8'h02, 8'h01};
   logic [23:0] led_in = {8'h44, 8'h22, 8'h11};
   logic [7:0] abcdefgh, digit, led;
   logic [2:0] gnt;
   logic [1:0] owner_idx;
   logic switch_pulse;
   logic [7:0] seg_e [3] = '{8'hA5, 8'h3C, 8'h0F};
   logic [7:0] dig_e [3] = '{8'h01, 8'h02, 8'h04};
   logic [7:0] led_e [3] = '{8'h11, 8'h22, 8'h44};
   int errors = 0, checks = 0;
   display_share_arbiter #(.n_req(3), .dwell_cycles(16)) dut (
      .clk(clk), .rst(rst), .req(req), .seg_in(seg_in), .digit_in(digit_in), .led_in(led_in),
      .abcdefgh(abcdefgh), .digit(digit), .led(led), .gnt(gnt), .owner_idx(owner_idx),
      .switch_pulse(switch_pulse)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic granted(input int idx);
      check("grant_gnt", gnt, 32'(1 << idx));
      check("grant_pulse", switch_pulse, 1);
      check("grant_owner", owner_idx, idx);
   endtask
   task automatic hold(input int idx, input int n);
      for (int i = 1; i <= n; i++) begin
         step();
         check("hold_gnt", gnt, 32'(1 << idx));
         check("hold_pulse", switch_pulse, 0);
         if (i == 1) begin
            check("seg", abcdefgh, seg_e[idx]);
            check("digit", digit, dig_e[idx]);
            check("led", led, led_e[idx]);
         end
      end
      step();
      check("blank_gnt", gnt, 0);
      check("blank_seg", abcdefgh, 0);
      check("blank_digit", digit, 0);
      check("blank_led", led, 0);
   endtask
   initial begin
      int bad, pulses;
      step();
      step();
      check("rst_gnt", gnt, 0);
      check("rst_owner", owner_idx, 2);
      check("rst_seg", abcdefgh, 0);
      check("rst_pulse", switch_pulse, 0);
      rst = 1'b0;
      step();
      check("idle_gnt", gnt, 0);
      req = 3'b001;
      step();
      granted(0);
      check("first_seg_latency", abcdefgh, 0);
      req = 3'b111;
      hold(0, 15);
      step();
      granted(1);
      hold(1, 15);
      step();
      granted(2);
      hold(2, 15);
      step();
      granted(0);
      rst = 1'b1;
      req = 3'b000;
      step();
      check("rst2_gnt", gnt, 0);
      check("rst2_owner", owner_idx, 2);
      rst = 1'b0;
      req = 3'b010;
      step();
      granted(1);
      repeat (5) step();
      req = 3'b000;
      step();
      check("drop_blank_gnt", gnt, 0);
      check("drop_blank_seg", abcdefgh, 0);
      step();
      check("idle_gnt2", gnt, 0);
      check("idle_owner", owner_idx, 1);
      step();
      check("idle_seg", abcdefgh, 0);
      check("idle_pulse", switch_pulse, 0);
      req = 3'b010;
      step();
      granted(1);
      repeat (9) step();
      rst = 1'b1;
      step();
      check("midrst_gnt", gnt, 0);
      check("midrst_seg", abcdefgh, 0);
      check("midrst_owner", owner_idx, 2);
      check("midrst_pulse", switch_pulse, 0);
      rst = 1'b0;
      step();
      granted(1);
      req = 3'b110;
      hold(1, 15);
      req = 3'b100;
      step();
      granted(2);
      bad = 0;
      pulses = 0;
      for (int i = 0; i < 110; i++) begin
         step();
         if (gnt !== 3'b100) bad++;
         if (switch_pulse) pulses++;
      end
      check("sole_gnt_changes", bad, 0);
      check("sole_extra_pulses", pulses, 0);
      check("sole_seg", abcdefgh, 8'h0F);
      req = 3'b000;
      step();
      check("sole_drop_blank", gnt, 0);
      step();
      check("sole_idle_owner", owner_idx, 2);
      req = 3'b100;
      step();
      granted(2);
      repeat (3) step();
      req = 3'b101;
`ifdef DISPLAY_ARB_PREEMPT_EN
      hold(2, 0);
`else
      hold(2, 12);
`endif
      step();
      granted(0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
